ip_tx_hdr: RTL and testbench



---
 rtl/ip_pkg.sv | 21 ++
 rtl/check_sum.sv | 47 ++++
 rtl/ip_tx_hdr.sv | 219 +++++++++++++++++++++
 tb/tb_ip_tx_hdr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// ip_pkg: shared constants and FSM state type for the IPv4 transmit framer.
//   IP_VER / IP_IHL   : version and header length (32-bit words) placed in byte 0
//   IP_HDR_BYTES      : fixed header length in bytes (no options)
//   PROTO_*           : common upper-layer protocol numbers
//   ip_state_e        : framer FSM states
package ip_pkg;

  localparam logic [3:0] IP_VER       = 4'd4;
  localparam logic [3:0] IP_IHL       = 4'd5;
  localparam int         IP_HDR_BYTES = 20;

  localparam logic [7:0] PROTO_ICMP = 8'h01;
  localparam logic [7:0] PROTO_UDP  = 8'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } ip_state_e;

endpackage

// File: rtl/check_sum.sv
// check_sum: combinational IPv4 header checksum (RFC 791 ones-complement sum of
// the ten header half-words with the checksum field taken as zero).
// Ports:
//   ver_i, hdr_len_i  : version / IHL nibbles
//   tos_i             : type of service
//   total_len_i       : total packet length
//   id_i              : identification
//   flags_off_i       : flags + fragment offset word
//   ttl_i, protocol_i : time to live, protocol
//   src_ip_i, dst_ip_i: addresses
//   csum_o            : header checksum
module check_sum (
  input  logic [3:0]  ver_i,
  input  logic [3:0]  hdr_len_i,
  input  logic [7:0]  tos_i,
  input  logic [15:0] total_len_i,
  input  logic [15:0] id_i,
  input  logic [15:0] flags_off_i,
  input  logic [7:0]  ttl_i,
  input  logic [7:0]  protocol_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  output logic [15:0] csum_o
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Nine 16-bit words fit in 20 bits; two end-around-carry folds always
  // bring the result back to 16 bits (the second fold cannot carry again).
  always_comb begin
    sum   = {4'd0, ver_i, hdr_len_i, tos_i}
          + {4'd0, total_len_i}
          + {4'd0, id_i}
          + {4'd0, flags_off_i}
          + {4'd0, ttl_i, protocol_i}
          + {4'd0, src_ip_i[31:16]}
          + {4'd0, src_ip_i[15:0]}
          + {4'd0, dst_ip_i[31:16]}
          + {4'd0, dst_ip_i[15:0]};
    fold1  = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2  = fold1[15:0] + {15'd0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/ip_tx_hdr.sv
// ip_tx_hdr: byte-serial IPv4 transmit framer. On tx_start it captures the
// packet fields, emits the 20-byte IPv4 header and then passes the payload
// stream straight through to the MAC side with no added latency.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   tx_start / tx_busy             : packet request / packet in progress
//   src_ip, dst_ip, protocol,
//   payload_len                    : packet fields, sampled on accepted start
//   pay_data/valid/last/ready      : payload stream in
//   m_data/valid/last/ready        : IP packet stream out
//   len_err                        : payload length mismatch pulse
// Build option: define IP_TX_LEN_CHECK_EN to end the packet on the counted
// payload_len byte instead of on pay_last, flagging mismatches on len_err.
module ip_tx_hdr
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL_DEF   = 8'd64,
  parameter logic [7:0]  TOS_DEF   = 8'h00,
  parameter logic [15:0] FLAGS_OFF = 16'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  output logic        tx_busy,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [7:0]  protocol,
  input  logic [15:0] payload_len,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  input  logic        pay_last,
  output logic        pay_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        len_err
);

  localparam logic [4:0] HDR_LAST = 5'(IP_HDR_BYTES - 1);

  ip_state_e   state_q, state_d;
  logic [4:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [31:0] src_q, dst_q;
  logic [7:0]  proto_q;
  logic [15:0] plen_q, tlen_q, id_lat_q;
  logic [15:0] csum;
  logic [7:0]  hdr_byte;
  logic        start_acc;

`ifdef IP_TX_LEN_CHECK_EN
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic        early_q, early_d;
  logic        cnt_last;
`endif

  assign start_acc = (state_q == IDLE) && tx_start;
  assign tx_busy   = (state_q != IDLE);

  // Checksum is purely combinational from the captured fields, so it is
  // already valid on the first HDR cycle and needs no extra register.
  check_sum u_check_sum (
    .ver_i       (IP_VER),
    .hdr_len_i   (IP_IHL),
    .tos_i       (TOS_DEF),
    .total_len_i (tlen_q),
    .id_i        (id_lat_q),
    .flags_off_i (FLAGS_OFF),
    .ttl_i       (TTL_DEF),
    .protocol_i  (proto_q),
    .src_ip_i    (src_q),
    .dst_ip_i    (dst_q),
    .csum_o      (csum)
  );

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt_q)
      5'd0:    hdr_byte = {IP_VER, IP_IHL};
      5'd1:    hdr_byte = TOS_DEF;
      5'd2:    hdr_byte = tlen_q[15:8];
      5'd3:    hdr_byte = tlen_q[7:0];
      5'd4:    hdr_byte = id_lat_q[15:8];
      5'd5:    hdr_byte = id_lat_q[7:0];
      5'd6:    hdr_byte = FLAGS_OFF[15:8];
      5'd7:    hdr_byte = FLAGS_OFF[7:0];
      5'd8:    hdr_byte = TTL_DEF;
      5'd9:    hdr_byte = proto_q;
      5'd10:   hdr_byte = csum[15:8];
      5'd11:   hdr_byte = csum[7:0];
      5'd12:   hdr_byte = src_q[31:24];
      5'd13:   hdr_byte = src_q[23:16];
      5'd14:   hdr_byte = src_q[15:8];
      5'd15:   hdr_byte = src_q[7:0];
      5'd16:   hdr_byte = dst_q[31:24];
      5'd17:   hdr_byte = dst_q[23:16];
      5'd18:   hdr_byte = dst_q[15:8];
      5'd19:   hdr_byte = dst_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

`ifdef IP_TX_LEN_CHECK_EN
  // PAY is only entered with payload_len >= 1, so the subtraction cannot wrap there.
  assign cnt_last = (pay_cnt_q == (plen_q - 16'd1));
`endif

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    ip_id_d   = ip_id_q;
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    pay_ready = 1'b0;
    len_err   = 1'b0;
`ifdef IP_TX_LEN_CHECK_EN
    pay_cnt_d = pay_cnt_q;
    early_d   = early_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d   = HDR;
          hdr_cnt_d = 5'd0;
`ifdef IP_TX_LEN_CHECK_EN
          pay_cnt_d = 16'd0;
          early_d   = 1'b0;
`endif
        end
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_byte;
        m_last  = (hdr_cnt_q == HDR_LAST) && (plen_q == 16'd0);
        if (m_ready) begin
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = 5'd0;
            if (plen_q == 16'd0) begin
              state_d = IDLE;
              ip_id_d = ip_id_q + 16'd1;
            end else begin
              state_d = PAY;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 5'd1;
          end
        end
      end
      PAY: begin
        m_data    = pay_data;
        m_valid   = pay_valid;
        pay_ready = m_ready;
`ifdef IP_TX_LEN_CHECK_EN
        // The byte count, not pay_last, decides where the packet ends; a
        // pay_last seen too early is remembered and reported at the end.
        m_last = cnt_last;
        if (pay_valid && m_ready) begin
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (cnt_last) begin
            len_err = early_q || !pay_last;
            state_d = IDLE;
            ip_id_d = ip_id_q + 16'd1;
          end else if (pay_last) begin
            early_d = 1'b1;
          end
        end
`else
        m_last = pay_last;
        if (pay_valid && m_ready && pay_last) begin
          state_d = IDLE;
          ip_id_d = ip_id_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_cnt_q <= 5'd0;
      ip_id_q   <= 16'd0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      proto_q   <= 8'd0;
      plen_q    <= 16'd0;
      tlen_q    <= 16'd0;
      id_lat_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      ip_id_q   <= ip_id_d;
      if (start_acc) begin
        src_q    <= src_ip;
        dst_q    <= dst_ip;
        proto_q  <= protocol;
        plen_q   <= payload_len;
        tlen_q   <= payload_len + 16'd20;
        id_lat_q <= ip_id_q;
      end
    end
  end

`ifdef IP_TX_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pay_cnt_q <= 16'd0;
      early_q   <= 1'b0;
    end else begin
      pay_cnt_q <= pay_cnt_d;
      early_q   <= early_d;
    end
  end
`endif

endmodule

// File: tb/tb_ip_tx_hdr.sv
// tb_ip_tx_hdr: directed self-checking bench for the IPv4 transmit framer.
module tb_ip_tx_hdr;

  logic        clk;
  logic        rst;
  logic        tx_start;
  logic        tx_busy;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [7:0]  protocol;
  logic [15:0] payload_len;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        pay_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        len_err;

  int total = 0;
  int bad   = 0;

  ip_tx_hdr dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .src_ip      (src_ip),
    .dst_ip      (dst_ip),
    .protocol    (protocol),
    .payload_len (payload_len),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .pay_last    (pay_last),
    .pay_ready   (pay_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference header: default TTL 64, TOS 0, DF flag, with an independent
  // ones-complement checksum.
  function automatic logic [159:0] makeHdr(input logic [31:0] src, input logic [31:0] dst,
                                           input logic [7:0] proto, input logic [15:0] len,
                                           input logic [15:0] id);
    logic [15:0] tl;
    logic [31:0] s;
    logic [15:0] cs;
    tl = len + 16'd20;
    s  = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + {16'd0, 8'd64, proto}
       + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    s  = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s  = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    return {16'h4500, tl, id, 16'h4000, 8'd64, proto, cs, src, dst};
  endfunction

  // Sends one packet and checks every presented byte. Payload byte i is A0+i;
  // pay_last is raised on payload byte lastAt (1-based). expLastIdx is the
  // 0-based output index expected to carry m_last.
  task automatic applyStimulus(input logic [159:0] hdr, input logic [31:0] src,
                               input logic [31:0] dst, input logic [7:0] proto,
                               input logic [15:0] len, input int nPay, input int lastAt,
                               input int expLastIdx, input bit expErr,
                               input bit randReady, input int pulseAt);
    logic [7:0] expB [0:63];
    int  k;
    int  pidx;
    int  cyc;
    bit  done;
    for (int i = 0; i < 20; i++) expB[i] = hdr[159 - 8*i -: 8];
    for (int i = 20; i < 64; i++) expB[i] = 8'hA0 + 8'(i - 20);
    @(negedge clk);
    src_ip = src; dst_ip = dst; protocol = proto; payload_len = len;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    k = 0; pidx = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      cyc++;
      m_ready   = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_start  = (cyc == pulseAt);
      pay_valid = (pidx < nPay);
      pay_data  = 8'hA0 + 8'(pidx);
      pay_last  = ((pidx + 1) == lastAt);
      #1;
      if (cyc == 1) checkOutput("busy_rise", 32'(tx_busy), 32'd1);
      if (k < 20) begin
        checkOutput($sformatf("hdr_valid[%0d]", k), 32'(m_valid), 32'd1);
        checkOutput($sformatf("hdr_byte[%0d]", k), 32'(m_data), 32'(expB[k]));
        checkOutput("pay_ready_hdr", 32'(pay_ready), 32'd0);
      end
      if (m_valid && m_ready) begin
        if (k >= 20) begin
          checkOutput($sformatf("pay_byte[%0d]", k), 32'(m_data), 32'(expB[k]));
          pidx++;
        end
        checkOutput($sformatf("m_last[%0d]", k), 32'(m_last), 32'(k == expLastIdx));
        checkOutput($sformatf("len_err[%0d]", k), 32'(len_err), 32'(expErr && (k == expLastIdx)));
        if (k == expLastIdx) done = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    checkOutput("pkt_timeout", 32'(done), 32'd1);
    tx_start  = 1'b0;
    m_ready   = 1'b1;
    pay_valid = 1'b1;
    pay_last  = 1'b0;
    #1;
    checkOutput("busy_fall", 32'(tx_busy), 32'd0);
    checkOutput("idle_valid", 32'(m_valid), 32'd0);
    checkOutput("idle_pay_ready", 32'(pay_ready), 32'd0);
    pay_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("no_queued_start", 32'(tx_busy), 32'd0);
  endtask

  initial begin : main
    logic [159:0] h;
    rst = 1'b1; tx_start = 1'b0; src_ip = '0; dst_ip = '0; protocol = '0;
    payload_len = '0; pay_data = '0; pay_valid = 1'b0; pay_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_last", 32'(m_last), 32'd0);
    checkOutput("rst_data", 32'(m_data), 32'd0);
    checkOutput("rst_pay_ready", 32'(pay_ready), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0;

    $display("[TB] packet 1: UDP, 8 payload bytes, id 0");
    applyStimulus(160'h4500001C000040004011B774C0A8010AC0A80102,
                  32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd8, 8, 8, 27, 1'b0, 1'b0, -1);

    $display("[TB] packet 2: same packet, random m_ready stalls, id 1");
    applyStimulus(160'h4500001C000140004011B773C0A8010AC0A80102,
                  32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd8, 8, 8, 27, 1'b0, 1'b1, -1);

    $display("[TB] packet 3: zero-length payload, id 2");
    applyStimulus(makeHdr(32'h0A000001, 32'h0A0000FE, 8'h01, 16'd0, 16'd2),
                  32'h0A000001, 32'h0A0000FE, 8'h01, 16'd0, 0, 0, 19, 1'b0, 1'b0, -1);

    $display("[TB] packet 4: tx_start pulsed during header, id 3");
    applyStimulus(makeHdr(32'hAC100001, 32'hAC100002, 8'h11, 16'd2, 16'd3),
                  32'hAC100001, 32'hAC100002, 8'h11, 16'd2, 2, 2, 21, 1'b0, 1'b0, 5);

    $display("[TB] packet 5: reset at header byte 7, id 4");
    h = makeHdr(32'hC0A80001, 32'hC0A80063, 8'h11, 16'd16, 16'd4);
    @(negedge clk);
    src_ip = 32'hC0A80001; dst_ip = 32'hC0A80063; protocol = 8'h11; payload_len = 16'd16;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      checkOutput($sformatf("pre_rst_byte[%0d]", k), 32'(m_data), 32'(h[159 - 8*k -: 8]));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("mid_rst_last", 32'(m_last), 32'd0);
    rst = 1'b0;
    applyStimulus(makeHdr(32'hC0A80001, 32'hC0A80063, 8'h11, 16'd3, 16'd0),
                  32'hC0A80001, 32'hC0A80063, 8'h11, 16'd3, 3, 3, 22, 1'b0, 1'b0, -1);

    $display("[TB] packet 6: length 4 with pay_last on payload byte 2, id 1");
`ifdef IP_TX_LEN_CHECK_EN
    applyStimulus(makeHdr(32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd4, 16'd1),
                  32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd4, 4, 2, 23, 1'b1, 1'b0, -1);
`else
    applyStimulus(makeHdr(32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd4, 16'd1),
                  32'hC0A8010A, 32'hC0A80102, 8'h11, 16'd4, 4, 2, 21, 1'b0, 1'b0, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
